// File: rtl/rgb_driver.sv
`default_nettype none
// ============================================================================
// Module   : rgb_driver
// Purpose  : WS2812-style single-wire serializer; pulse-width-coded bits with
//            run-time prescaler, bit period and high times.
//            Define RGB_DRIVER_LSB_FIRST_EN to shift bytes out LSB first.
// Revision : 1.0
// ============================================================================
module rgb_driver (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [7:0]  clk_div,
    input  logic [15:0] clk_max,
    input  logic [7:0]  data,
    input  logic [15:0] hi_in_1,
    input  logic [15:0] hi_in_0,
    output logic        no_pulse,
    output logic        out
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t      r_state, w_state_next;
    logic [7:0]  r_presc, w_presc_next;
    logic [15:0] r_tick, w_tick_next;
    logic [2:0]  r_bit, w_bit_next;
    logic [7:0]  r_shift, w_shift_next;
    logic [7:0]  r_div, w_div_next;
    logic [15:0] r_period_m1, w_period_m1_next;
    logic [15:0] r_hi1, w_hi1_next;
    logic [15:0] r_hi0, w_hi0_next;
    logic        r_out, w_out_next;
    logic        r_no_pulse, w_no_pulse_next;
    logic        w_load;
    logic        w_cur_bit;
    logic [7:0]  w_shift_adv;

`ifdef RGB_DRIVER_LSB_FIRST_EN
    assign w_shift_adv = {1'b0, r_shift[7:1]};
    assign w_cur_bit   = w_shift_next[0];
`else
    assign w_shift_adv = {r_shift[6:0], 1'b0};
    assign w_cur_bit   = w_shift_next[7];
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_presc     <= 8'd0;
            r_tick      <= 16'd0;
            r_bit       <= 3'd0;
            r_shift     <= 8'd0;
            r_div       <= 8'd0;
            r_period_m1 <= 16'd0;
            r_hi1       <= 16'd0;
            r_hi0       <= 16'd0;
            r_out       <= 1'b0;
            r_no_pulse  <= 1'b1;
        end else begin
            r_state     <= w_state_next;
            r_presc     <= w_presc_next;
            r_tick      <= w_tick_next;
            r_bit       <= w_bit_next;
            r_shift     <= w_shift_next;
            r_div       <= w_div_next;
            r_period_m1 <= w_period_m1_next;
            r_hi1       <= w_hi1_next;
            r_hi0       <= w_hi0_next;
            r_out       <= w_out_next;
            r_no_pulse  <= w_no_pulse_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_presc_next     = r_presc;
        w_tick_next      = r_tick;
        w_bit_next       = r_bit;
        w_shift_next     = r_shift;
        w_div_next       = r_div;
        w_period_m1_next = r_period_m1;
        w_hi1_next       = r_hi1;
        w_hi0_next       = r_hi0;
        w_load           = 1'b0;

        case (r_state)
            IDLE: begin
                if (enable) begin
                    w_load = 1'b1;
                end
            end
            SEND: begin
                if (r_presc == r_div) begin
                    w_presc_next = 8'd0;
                    if (r_tick == r_period_m1) begin
                        w_tick_next = 16'd0;
                        if (r_bit == 3'd7) begin
                            if (enable) begin
                                w_load = 1'b1;
                            end else begin
                                w_state_next = IDLE;
                            end
                        end else begin
                            w_bit_next   = r_bit + 3'd1;
                            w_shift_next = w_shift_adv;
                        end
                    end else begin
                        w_tick_next = r_tick + 16'd1;
                    end
                end else begin
                    w_presc_next = r_presc + 8'd1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        // Byte start: new data and timing snapshot, counters restart at bit 0.
        if (w_load) begin
            w_state_next     = SEND;
            w_shift_next     = data;
            w_div_next       = clk_div;
            w_period_m1_next = (clk_max == 16'd0) ? 16'd0 : (clk_max - 16'd1);
            w_hi1_next       = hi_in_1;
            w_hi0_next       = hi_in_0;
            w_presc_next     = 8'd0;
            w_tick_next      = 16'd0;
            w_bit_next       = 3'd0;
        end

        // Outputs are precomputed for the period that follows this edge.
        w_no_pulse_next = (w_state_next != SEND);
        w_out_next      = (w_state_next == SEND) &&
                          (w_tick_next < (w_cur_bit ? w_hi1_next : w_hi0_next));
    end

    assign out      = r_out;
    assign no_pulse = r_no_pulse;

endmodule
`default_nettype wire

// File: tb/tb_rgb_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_rgb_driver
// Purpose  : Directed self-checking bench for rgb_driver.
// Revision : 1.0
// ============================================================================
module tb_rgb_driver;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [7:0]  clk_div;
    logic [15:0] clk_max;
    logic [7:0]  data;
    logic [15:0] hi_in_1;
    logic [15:0] hi_in_0;
    logic        no_pulse;
    logic        out;

    int n_tests;
    int n_fail;

    rgb_driver dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .clk_div  (clk_div),
        .clk_max  (clk_max),
        .data     (data),
        .hi_in_1  (hi_in_1),
        .hi_in_0  (hi_in_0),
        .no_pulse (no_pulse),
        .out      (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
        $fatal(1);
    end

    // Expected line level at clock c (0-based) of a byte.
    function automatic logic exp_out(input int c, input int d, input int mx,
                                     input int h1, input int h0, input logic [7:0] b);
        int dd, pp, bp, tick, hh;
        logic bv;
        dd   = d + 1;
        pp   = (mx == 0) ? 1 : mx;
        bp   = c / (pp * dd);
        tick = (c % (pp * dd)) / dd;
`ifdef RGB_DRIVER_LSB_FIRST_EN
        bv   = b[bp];
`else
        bv   = b[7 - bp];
`endif
        hh   = bv ? h1 : h0;
        return (tick < hh);
    endfunction

    task automatic force_idle();
        @(negedge clk);
        enable = 1'b0;
        reset  = 1'b0;
        @(negedge clk);
        reset  = 1'b1;
    endtask

    task automatic set_cfg(input int d, input int mx, input int h1, input int h0,
                           input logic [7:0] b);
        clk_div = d[7:0];
        clk_max = mx[15:0];
        hi_in_1 = h1[15:0];
        hi_in_0 = h0[15:0];
        data    = b;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        set_cfg(0, 20, 15, 8, 8'hA5);
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++;
            if (out !== 1'b0 || no_pulse !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_hold cyc%0d: out=%b no_pulse=%b, required out=0 no_pulse=1",
                         i, out, no_pulse);
            end
        end
        reset = 1'b1;
        @(negedge clk);
        n_tests++;
        if (out !== 1'b1 || no_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_first_bit: out=%b no_pulse=%b, required out=1 no_pulse=0",
                     out, no_pulse);
        end
        force_idle();
    endtask

    // Single bytes under several timing configurations.
    task automatic test_coding();
        int         t_div [4] = '{0, 2, 0, 0};
        int         t_max [4] = '{20, 20, 20, 0};
        int         t_h1  [4] = '{15, 15, 25, 1};
        int         t_h0  [4] = '{8, 8, 0, 0};
        logic [7:0] t_dat [4] = '{8'hA5, 8'hA5, 8'hC3, 8'hA5};
        int         len;
        logic       e;
        for (int k = 0; k < 4; k++) begin
            len = 8 * ((t_max[k] == 0) ? 1 : t_max[k]) * (t_div[k] + 1);
            @(negedge clk);
            set_cfg(t_div[k], t_max[k], t_h1[k], t_h0[k], t_dat[k]);
            enable = 1'b1;
            @(negedge clk);
            enable = 1'b0;
            set_cfg(5, 3, 0, 0, 8'h00);
            for (int c = 0; c < len; c++) begin
                e = exp_out(c, t_div[k], t_max[k], t_h1[k], t_h0[k], t_dat[k]);
                n_tests++;
                if (out !== e || no_pulse !== 1'b0) begin
                    n_fail++;
                    $display("FAIL coding cfg%0d clk%0d: out=%b no_pulse=%b, required out=%b no_pulse=0",
                             k, c, out, no_pulse, e);
                end
                @(negedge clk);
            end
            n_tests++;
            if (out !== 1'b0 || no_pulse !== 1'b1) begin
                n_fail++;
                $display("FAIL coding_end cfg%0d: out=%b no_pulse=%b, required out=0 no_pulse=1",
                         k, out, no_pulse);
            end
        end
    endtask

    task automatic test_stop();
        logic e;
        @(negedge clk);
        set_cfg(0, 20, 15, 8, 8'h3C);
        enable = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 160; c++) begin
            e = exp_out(c, 0, 20, 15, 8, 8'h3C);
            n_tests++;
            if (out !== e || no_pulse !== 1'b0) begin
                n_fail++;
                $display("FAIL stop clk%0d: out=%b no_pulse=%b, required out=%b no_pulse=0",
                         c, out, no_pulse, e);
            end
            if (c == 50) enable = 1'b0;
            @(negedge clk);
        end
        for (int i = 0; i < 20; i++) begin
            n_tests++;
            if (out !== 1'b0 || no_pulse !== 1'b1) begin
                n_fail++;
                $display("FAIL stop_idle cyc%0d: out=%b no_pulse=%b, required out=0 no_pulse=1",
                         i, out, no_pulse);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] cur;
        int         gc;
        logic       e;
        gc = 0;
        @(negedge clk);
        set_cfg(0, 20, 15, 8, 8'h10);
        enable = 1'b1;
        cur = 8'h10;
        @(negedge clk);
        for (int byt = 0; byt < 3; byt++) begin
            for (int c = 0; c < 160; c++) begin
                e = exp_out(c, 0, 20, 15, 8, cur);
                n_tests++;
                if (out !== e || no_pulse !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stream byte%0d clk%0d: out=%b no_pulse=%b, required out=%b no_pulse=0",
                             byt, c, out, no_pulse, e);
                end
                gc++;
                if (gc % 8 == 0) data = data + 8'd1;
                if (c == 159) cur = data;
                @(negedge clk);
            end
        end
        force_idle();
    endtask

    task automatic test_mid_reset();
        logic e;
        @(negedge clk);
        set_cfg(0, 20, 15, 8, 8'hFF);
        enable = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 85; c++) begin
            e = exp_out(c, 0, 20, 15, 8, 8'hFF);
            n_tests++;
            if (out !== e) begin
                n_fail++;
                $display("FAIL midrst_pre clk%0d: out=%b, required %b", c, out, e);
            end
            @(negedge clk);
        end
        #2;
        reset = 1'b0;
        #1;
        n_tests++;
        if (out !== 1'b0 || no_pulse !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_async: out=%b no_pulse=%b, required out=0 no_pulse=1",
                     out, no_pulse);
        end
        @(negedge clk);
        n_tests++;
        if (out !== 1'b0 || no_pulse !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_hold: out=%b no_pulse=%b, required out=0 no_pulse=1",
                     out, no_pulse);
        end
        data  = 8'h80;
        reset = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        for (int c = 0; c < 160; c++) begin
            e = exp_out(c, 0, 20, 15, 8, 8'h80);
            n_tests++;
            if (out !== e || no_pulse !== 1'b0) begin
                n_fail++;
                $display("FAIL midrst_fresh clk%0d: out=%b no_pulse=%b, required out=%b no_pulse=0",
                         c, out, no_pulse, e);
            end
            @(negedge clk);
        end
        n_tests++;
        if (out !== 1'b0 || no_pulse !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_end: out=%b no_pulse=%b, required out=0 no_pulse=1",
                     out, no_pulse);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        enable  = 1'b0;
        set_cfg(0, 20, 15, 8, 8'h00);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        test_reset();
        test_coding();
        test_stop();
        test_back_to_back();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
